// File: rtl/case_5_mul_pipe_hs.sv
// ----------------------------------------------------------------------------
// case_5_mul_pipe_hs
//   Pipelined signed/unsigned multiplier with a valid/ready handshake and
//   bubble-collapsing backpressure. The full-width product is formed and
//   registered in S0. Later stages only delay it. Range checking and optional
//   clamping are combinational on the last stage register.
//
// Parameters
//   ID          instance tag, no functional effect
//   NUM_STAGE   register stages (1..8), equal to the latency in cycles
//   din0_WIDTH  operand A width
//   din1_WIDTH  operand B width
//   dout_WIDTH  result width; may be narrower than din0_WIDTH+din1_WIDTH
//
// Ports
//   ap_clk, ap_rst_n    clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (din0, din1, mode)
//   mode                bit0: din0 signed, bit1: din1 signed
//   out_valid/out_ready result handshake (dout, dout_ovf)
//   dout_ovf            full product is outside the dout_WIDTH range
//
// Build option
//   CASE_5_MUL_SAT_EN   when defined, dout clamps to the range limit on overflow
// ----------------------------------------------------------------------------
module case_5_mul_pipe_hs #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 4,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_ovf
);

  localparam int P = din0_WIDTH + din1_WIDTH;
  localparam int W = dout_WIDTH;

  // Operands extended to P bits. The low P bits of a P x P product are the
  // same for signed and unsigned interpretation, so one unsigned multiplier
  // serves every mode, and the exact product always fits in P bits.
  logic [P-1:0] a_x, b_x, prod_c;

  always_comb begin
    a_x    = mode[0] ? P'($signed(din0)) : P'(din0);
    b_x    = mode[1] ? P'($signed(din1)) : P'(din1);
    prod_c = a_x * b_x;
  end

  // Bit 0 of vld_pipe is the input beat. Bit i+1 is the valid bit of stage i.
  logic [NUM_STAGE-1:0]        stg_vld;
  logic [NUM_STAGE:0]          vld_pipe;
  logic [NUM_STAGE-1:0]        adv;
  logic [NUM_STAGE-1:0][P-1:0] prod_q, prod_d;
  logic [NUM_STAGE-1:0]        sgn_q, sgn_d;

  assign vld_pipe = {stg_vld, in_valid};

  // A stage advances if it is empty or the stage after it advances. This
  // chain lets an empty stage fill while the stages behind it are stalled.
  always_comb begin
    logic a;
    a = ~stg_vld[NUM_STAGE-1] | out_ready;
    adv[NUM_STAGE-1] = a;
    for (int i = NUM_STAGE - 2; i >= 0; i--) begin
      a      = ~stg_vld[i] | a;
      adv[i] = a;
    end
  end

  assign in_ready = adv[0];

  always_comb begin
    prod_d[0] = prod_c;
    sgn_d[0]  = |mode;
    for (int i = 1; i < NUM_STAGE; i++) begin
      prod_d[i] = prod_q[i-1];
      sgn_d[i]  = sgn_q[i-1];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stg_vld <= '0;
      prod_q  <= '0;
      sgn_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        if (adv[i]) begin
          stg_vld[i] <= vld_pipe[i];
          // Data moves only with a real beat, so bubbles do not disturb it.
          if (vld_pipe[i]) begin
            prod_q[i] <= prod_d[i];
            sgn_q[i]  <= sgn_d[i];
          end
        end
      end
    end
  end

  logic [P-1:0] last;
  logic         last_sgn;

  assign out_valid = stg_vld[NUM_STAGE-1];
  assign last      = prod_q[NUM_STAGE-1];
  assign last_sgn  = sgn_q[NUM_STAGE-1];

  if (W >= P) begin : g_wide
    // Every product fits, so the result is only extended per its signedness.
    assign dout_ovf = 1'b0;
    assign dout     = last_sgn ? W'($signed(last)) : W'(last);
  end else begin : g_narrow
    logic         ovf;
    logic [W-1:0] trunc;

    always_comb begin
      trunc = last[W-1:0];
      // Signed: the bits from W-1 up must all copy the sign.
      // Unsigned: the bits from W up must be zero.
      if (last_sgn) ovf = (last[P-1:W-1] != {(P-W+1){last[P-1]}});
      else          ovf = |last[P-1:W];
    end

    assign dout_ovf = ovf;

`ifdef CASE_5_MUL_SAT_EN
    localparam logic [W-1:0] SMIN = W'(1) << (W - 1);
    localparam logic [W-1:0] SMAX = ~SMIN;
    logic [W-1:0] sat;

    // The sign of the product sets the direction of the clamp. An unsigned
    // result is never negative, so it can only clamp high.
    always_comb begin
      if (last_sgn) sat = last[P-1] ? SMIN : SMAX;
      else          sat = '1;
    end

    assign dout = ovf ? sat : trunc;
`else
    assign dout = trunc;
`endif
  end

endmodule

// File: tb/tb_case_5_mul_pipe_hs.sv
module tb_case_5_mul_pipe_hs;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, dout_ovf;
  logic [3:0] din0, din1;
  logic [1:0] mode;
  logic [7:0] dout;

  // narrow-result instance (dout_WIDTH=6)
  logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_dout_ovf;
  logic [3:0] n_din0, n_din1;
  logic [1:0] n_mode;
  logic [5:0] n_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  case_5_mul_pipe_hs u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .dout_ovf(dout_ovf)
  );

  case_5_mul_pipe_hs #(.dout_WIDTH(6)) u_nar (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .din0(n_din0), .din1(n_din1), .mode(n_mode),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .dout(n_dout), .dout_ovf(n_dout_ovf)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    ap_rst_n = 1'b0;
    in_valid = 0; out_ready = 1; din0 = 0; din1 = 0; mode = 0;
    n_in_valid = 0; n_out_ready = 1; n_din0 = 0; n_din1 = 0; n_mode = 0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h exp 00", dout); end
    n_cmp++; if (dout_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b exp 0", dout_ovf); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  // -6 * 3 = -18, visible exactly two edges after acceptance
  task automatic test_latency();
    @(posedge ap_clk); #1;
    in_valid = 1; din0 = 4'hA; din1 = 4'h3; mode = 2'b11; out_ready = 1;
    @(negedge ap_clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lat_in_ready got %b exp 1", in_ready); end
    @(posedge ap_clk); #1;
    in_valid = 0;
    @(negedge ap_clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early got %b exp 0", out_valid); end
    @(negedge ap_clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid got %b exp 1", out_valid); end
    n_cmp++; if (dout !== 8'hEE) begin n_bad++; $display("FAIL lat_dout got %h exp ee", dout); end
    n_cmp++; if (dout_ovf !== 1'b0) begin n_bad++; $display("FAIL lat_ovf got %b exp 0", dout_ovf); end
    @(negedge ap_clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_drain got %b exp 0", out_valid); end
  endtask

  // 15*15=225 unsigned, -8*15=-120 mixed, -8*-8=64 signed (fits 8-bit signed)
  task automatic test_modes();
    logic [1:0] m[3];
    logic [3:0] a[3], b[3];
    logic [7:0] e[3];
    m[0] = 2'b00; a[0] = 4'hF; b[0] = 4'hF; e[0] = 8'hE1;
    m[1] = 2'b01; a[1] = 4'h8; b[1] = 4'hF; e[1] = 8'h88;
    m[2] = 2'b11; a[2] = 4'h8; b[2] = 4'h8; e[2] = 8'h40;
    for (int c = 0; c < 5; c++) begin
      @(posedge ap_clk); #1;
      if (c < 3) begin in_valid = 1; mode = m[c]; din0 = a[c]; din1 = b[c]; end
      else in_valid = 0;
      @(negedge ap_clk);
      if (c >= 2) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL modes_valid[%0d] got %b exp 1", c-2, out_valid); end
        n_cmp++; if (dout !== e[c-2]) begin n_bad++; $display("FAIL modes_dout[%0d] got %h exp %h", c-2, dout, e[c-2]); end
        n_cmp++; if (dout_ovf !== 1'b0) begin n_bad++; $display("FAIL modes_ovf[%0d] got %b exp 0", c-2, dout_ovf); end
      end
    end
    @(negedge ap_clk);
  endtask

  // 10 unsigned beats (k+1)*3, out_ready low for cycles 3..7
  task automatic test_back_to_back();
    logic [7:0] e[10];
    int sent = 0, rcv = 0, occ = 0;
    bit prev_stall = 0;
    logic [7:0] prev_dout = 0;
    bit exp_rdy;
    e = '{8'd3, 8'd6, 8'd9, 8'd12, 8'd15, 8'd18, 8'd21, 8'd24, 8'd27, 8'd30};
    for (int c = 0; c < 60 && rcv < 10; c++) begin
      @(posedge ap_clk); #1;
      out_ready = !(c >= 3 && c <= 7);
      mode = 2'b00; din1 = 4'd3;
      if (sent < 10) begin in_valid = 1; din0 = 4'(sent + 1); end
      else in_valid = 0;
      @(negedge ap_clk);
      exp_rdy = (occ < 2) || out_ready;
      n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_in_ready c%0d got %b exp %b", c, in_ready, exp_rdy); end
      if (prev_stall) begin
        n_cmp++; if (out_valid !== 1'b1 || dout !== prev_dout) begin
          n_bad++; $display("FAIL b2b_hold c%0d got v%b %h exp v1 %h", c, out_valid, dout, prev_dout); end
      end
      if (out_valid === 1'b1) begin
        n_cmp++; if (rcv >= 10 || dout !== e[rcv]) begin
          n_bad++; $display("FAIL b2b_dout idx%0d got %h exp %h", rcv, dout, (rcv < 10) ? e[rcv] : 8'hxx); end
      end
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
      if (in_valid && in_ready) begin sent++; occ++; end
      if (out_valid && out_ready) begin rcv++; occ--; end
    end
    n_cmp++; if (rcv != 10 || sent != 10) begin n_bad++; $display("FAIL b2b_count got sent%0d rcv%0d exp 10 10", sent, rcv); end
    @(posedge ap_clk); #1; in_valid = 0; out_ready = 1;
    @(negedge ap_clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_extra got %b exp 0", out_valid); end
  endtask

  // A=6 held in S1, B=20 fills the empty S0, C=49 waits on a full pipe
  task automatic test_bubble();
    @(posedge ap_clk); #1;
    out_ready = 0; mode = 2'b00; in_valid = 1; din0 = 4'd2; din1 = 4'd3;
    @(posedge ap_clk); #1; in_valid = 0;
    @(posedge ap_clk); #1;
    in_valid = 1; din0 = 4'd4; din1 = 4'd5;
    @(negedge ap_clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bub_accept got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || dout !== 8'd6) begin n_bad++; $display("FAIL bub_head got v%b %h exp v1 06", out_valid, dout); end
    for (int c = 0; c < 3; c++) begin
      @(posedge ap_clk); #1;
      in_valid = 1; din0 = 4'd7; din1 = 4'd7;
      @(negedge ap_clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bub_full c%0d got %b exp 0", c, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || dout !== 8'd6) begin n_bad++; $display("FAIL bub_hold c%0d got v%b %h exp v1 06", c, out_valid, dout); end
    end
    @(posedge ap_clk); #1; out_ready = 1;
    @(negedge ap_clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bub_release got %b exp 1", in_ready); end
    @(posedge ap_clk); #1; in_valid = 0;
    @(negedge ap_clk);
    n_cmp++; if (out_valid !== 1'b1 || dout !== 8'h14) begin n_bad++; $display("FAIL bub_b got v%b %h exp v1 14", out_valid, dout); end
    @(negedge ap_clk);
    n_cmp++; if (out_valid !== 1'b1 || dout !== 8'h31) begin n_bad++; $display("FAIL bub_c got v%b %h exp v1 31", out_valid, dout); end
    @(negedge ap_clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bub_drain got %b exp 0", out_valid); end
  endtask

  // 6-bit result: 64 (ovf), -16, -32 (boundary), 64 unsigned (ovf), -40 (ovf low)
  task automatic test_ovf();
    logic [1:0] m[5];
    logic [3:0] a[5], b[5];
    logic [5:0] e[5];
    logic       o[5];
    m[0] = 2'b11; a[0] = 4'h8; b[0] = 4'h8; o[0] = 1;
    m[1] = 2'b11; a[1] = 4'hC; b[1] = 4'h4; o[1] = 0; e[1] = 6'h30;
    m[2] = 2'b11; a[2] = 4'h4; b[2] = 4'h8; o[2] = 0; e[2] = 6'h20;
    m[3] = 2'b00; a[3] = 4'h8; b[3] = 4'h8; o[3] = 1;
    m[4] = 2'b11; a[4] = 4'h8; b[4] = 4'h5; o[4] = 1;
`ifdef CASE_5_MUL_SAT_EN
    e[0] = 6'h1F; e[3] = 6'h3F; e[4] = 6'h20;
`else
    e[0] = 6'h00; e[3] = 6'h00; e[4] = 6'h18;
`endif
    n_out_ready = 1;
    for (int c = 0; c < 7; c++) begin
      @(posedge ap_clk); #1;
      if (c < 5) begin n_in_valid = 1; n_mode = m[c]; n_din0 = a[c]; n_din1 = b[c]; end
      else n_in_valid = 0;
      @(negedge ap_clk);
      if (c >= 2) begin
        n_cmp++; if (n_out_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid[%0d] got %b exp 1", c-2, n_out_valid); end
        n_cmp++; if (n_dout !== e[c-2]) begin n_bad++; $display("FAIL ovf_dout[%0d] got %h exp %h", c-2, n_dout, e[c-2]); end
        n_cmp++; if (n_dout_ovf !== o[c-2]) begin n_bad++; $display("FAIL ovf_flag[%0d] got %b exp %b", c-2, n_dout_ovf, o[c-2]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge ap_clk); #1;
    out_ready = 0; mode = 2'b11; in_valid = 1; din0 = 4'h7; din1 = 4'h7;
    @(posedge ap_clk); #1; din0 = 4'h5;
    @(posedge ap_clk); #1; in_valid = 0;
    @(negedge ap_clk);
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rmid_full got v%b r%b exp v1 r0", out_valid, in_ready); end
    #1 ap_rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL rmid_dout got %h exp 00", dout); end
    n_cmp++; if (dout_ovf !== 1'b0) begin n_bad++; $display("FAIL rmid_ovf got %b exp 0", dout_ovf); end
    #1 ap_rst_n = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_stale c%0d got %b exp 0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_bubble();
    test_ovf();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
